// File: rtl/bht_branch_predictor.sv
// Fetch-stage branch predictor: PC-indexed table of saturating counters,
// JAL/branch target generation, and an IF stall while a JALR target is unresolved.
module bht_branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2,
    parameter int CTR_INIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic [31:0]           if_instr,
    output logic                  pred_valid,
    output logic                  pred_is_jump,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_next_pc,
    output logic                  pred_stall,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic                  jalr_resolve_valid,
    input  logic [ADDR_WIDTH-1:0] jalr_target,
    input  logic                  flush
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [CTR_BITS-1:0] CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(CTR_INIT);

    typedef enum logic {IDLE, WAIT_JALR} state_t;

    state_t                state_q, state_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_is_jump_q, pred_is_jump_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [ADDR_WIDTH-1:0] pred_next_pc_q, pred_next_pc_d;
    logic                  pred_stall_q, pred_stall_d;
    logic [CTR_BITS-1:0]   pht_q [DEPTH];
    logic [CTR_BITS-1:0]   upd_ctr_d;

    logic [INDEX_BITS-1:0] lkp_idx, upd_idx;
    logic [6:0]            opcode;
    logic [20:0]           j_imm;
    logic [12:0]           b_imm;
    logic [ADDR_WIDTH-1:0] j_target, b_target, seq_pc;
    logic                  unused_upd_pc_bits;

    assign lkp_idx  = if_pc[INDEX_BITS+1:2];
    assign upd_idx  = upd_pc[INDEX_BITS+1:2];
    assign opcode   = if_instr[6:0];
    assign j_imm    = {if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign b_imm    = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign j_target = if_pc + {{(ADDR_WIDTH-21){j_imm[20]}}, j_imm};
    assign b_target = if_pc + {{(ADDR_WIDTH-13){b_imm[12]}}, b_imm};
    assign seq_pc   = if_pc + ADDR_WIDTH'(4);
    assign unused_upd_pc_bits = ^{upd_pc[ADDR_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

    // Saturating step of the counter being trained by a commit.
    always_comb begin
        upd_ctr_d = pht_q[upd_idx];
        if (upd_taken && pht_q[upd_idx] != CTR_MAX)
            upd_ctr_d = pht_q[upd_idx] + 1'b1;
        else if (!upd_taken && pht_q[upd_idx] != '0)
            upd_ctr_d = pht_q[upd_idx] - 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        pred_valid_d   = 1'b0;
        pred_is_jump_d = pred_is_jump_q;
        pred_taken_d   = pred_taken_q;
        pred_next_pc_d = pred_next_pc_q;
        pred_stall_d   = pred_stall_q;
        if (flush) begin
            state_d      = IDLE;
            pred_stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pred_stall_d = 1'b0;
                    if (if_valid) begin
                        pred_valid_d   = 1'b1;
                        pred_is_jump_d = 1'b0;
                        pred_taken_d   = 1'b0;
                        pred_next_pc_d = seq_pc;
                        case (opcode)
                            OP_JAL: begin
                                pred_is_jump_d = 1'b1;
                                pred_taken_d   = 1'b1;
                                pred_next_pc_d = j_target;
                            end
                            OP_BR: begin
                                pred_is_jump_d = 1'b1;
                                pred_taken_d   = pht_q[lkp_idx][CTR_BITS-1];
                                if (pht_q[lkp_idx][CTR_BITS-1]) pred_next_pc_d = b_target;
                            end
                            OP_JALR: begin
                                // Target unknown: hold the previous next_pc until the ALU resolves it.
                                pred_valid_d   = 1'b0;
                                pred_is_jump_d = 1'b1;
                                pred_taken_d   = 1'b1;
                                pred_next_pc_d = pred_next_pc_q;
                                pred_stall_d   = 1'b1;
                                state_d        = WAIT_JALR;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_JALR: begin
                    if (jalr_resolve_valid) begin
                        pred_valid_d   = 1'b1;
                        pred_is_jump_d = 1'b1;
                        pred_taken_d   = 1'b1;
                        pred_next_pc_d = jalr_target;
                        pred_stall_d   = 1'b0;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pred_valid_q   <= 1'b0;
            pred_is_jump_q <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_next_pc_q <= '0;
            pred_stall_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) pht_q[i] <= CTR_RESET;
        end else if (rdy) begin
            state_q        <= state_d;
            pred_valid_q   <= pred_valid_d;
            pred_is_jump_q <= pred_is_jump_d;
            pred_taken_q   <= pred_taken_d;
            pred_next_pc_q <= pred_next_pc_d;
            pred_stall_q   <= pred_stall_d;
            if (upd_valid) pht_q[upd_idx] <= upd_ctr_d;
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_is_jump = pred_is_jump_q;
    assign pred_taken   = pred_taken_q;
    assign pred_next_pc = pred_next_pc_q;
    assign pred_stall   = pred_stall_q;
endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed bench for bht_branch_predictor with hand-computed expectations.
module tb_bht_branch_predictor;
    localparam logic [31:0] I_BR16 = 32'h0000_0863; // beq x0,x0,+16
    localparam logic [31:0] I_JALM8 = 32'hFF9F_F06F; // jal x0,-8
    localparam logic [31:0] I_JALR = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] I_NOP  = 32'h0000_0013; // addi x0,x0,0

    logic        clk = 1'b0, rst, rdy;
    logic        if_valid, upd_valid, upd_taken, jalr_resolve_valid, flush;
    logic [31:0] if_pc, if_instr, upd_pc, jalr_target;
    logic        pred_valid, pred_is_jump, pred_taken, pred_stall;
    logic [31:0] pred_next_pc;
    int checks = 0, errors = 0;

    bht_branch_predictor dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .pred_valid(pred_valid), .pred_is_jump(pred_is_jump), .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc), .pred_stall(pred_stall),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .jalr_resolve_valid(jalr_resolve_valid), .jalr_target(jalr_target), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        if_valid = 0; if_pc = 0; if_instr = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        jalr_resolve_valid = 0; jalr_target = 0; flush = 0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1; if_pc = pc; if_instr = instr;
        tick();
        if_valid = 0;
    endtask

    task automatic train(input logic tkn, input int n);
        for (int i = 0; i < n; i++) begin
            upd_valid = 1; upd_pc = 32'h100; upd_taken = tkn;
            tick();
        end
        upd_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; idle_inputs();
        tick(); tick();
        rst = 0;
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b exp 0", pred_valid); end
        checks++; if (pred_is_jump !== 1'b0) begin errors++; $display("FAIL rst_is_jump: got %0b exp 0", pred_is_jump); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %0b exp 0", pred_taken); end
        checks++; if (pred_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b exp 0", pred_stall); end
        checks++; if (pred_next_pc !== 32'h0) begin errors++; $display("FAIL rst_next_pc: got %h exp 0", pred_next_pc); end
    endtask

    task automatic test_branch_init();
        lookup(32'h100, I_BR16);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL br_init_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_is_jump !== 1'b1) begin errors++; $display("FAIL br_init_is_jump: got %0b exp 1", pred_is_jump); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL br_init_taken: got %0b exp 0", pred_taken); end
        checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL br_init_next_pc: got %h exp 104", pred_next_pc); end
        tick();
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL br_pulse_valid: got %0b exp 0", pred_valid); end
        checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL br_hold_next_pc: got %h exp 104", pred_next_pc); end
    endtask

    task automatic test_training();
        train(1, 2);                         // 1 -> 3
        lookup(32'h100, I_BR16);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %0b exp 1", pred_taken); end
        checks++; if (pred_next_pc !== 32'h110) begin errors++; $display("FAIL train_next_pc: got %h exp 110", pred_next_pc); end
        train(1, 5);                         // stays 3
        train(0, 3);                         // 3 -> 0
        lookup(32'h100, I_BR16);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_hi_taken: got %0b exp 0", pred_taken); end
        checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL sat_hi_next_pc: got %h exp 104", pred_next_pc); end
        train(0, 1);                         // stays 0
        train(1, 2);                         // 0 -> 2
        lookup(32'h100, I_BR16);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_lo_taken: got %0b exp 1", pred_taken); end
    endtask

    task automatic test_jal_and_other();
        lookup(32'h200, I_JALM8);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL jal_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %0b exp 1", pred_taken); end
        checks++; if (pred_next_pc !== 32'h1F8) begin errors++; $display("FAIL jal_next_pc: got %h exp 1f8", pred_next_pc); end
        lookup(32'h400, I_NOP);
        checks++; if (pred_is_jump !== 1'b0) begin errors++; $display("FAIL nop_is_jump: got %0b exp 0", pred_is_jump); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nop_taken: got %0b exp 0", pred_taken); end
        checks++; if (pred_next_pc !== 32'h404) begin errors++; $display("FAIL nop_next_pc: got %h exp 404", pred_next_pc); end
    endtask

    task automatic test_jalr();
        lookup(32'h300, I_JALR);
        checks++; if (pred_stall !== 1'b1) begin errors++; $display("FAIL jalr_stall: got %0b exp 1", pred_stall); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL jalr_valid: got %0b exp 0", pred_valid); end
        lookup(32'h500, I_NOP);
        tick();
        checks++; if (pred_stall !== 1'b1) begin errors++; $display("FAIL jalr_wait_stall: got %0b exp 1", pred_stall); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL jalr_wait_valid: got %0b exp 0", pred_valid); end
        jalr_resolve_valid = 1; jalr_target = 32'h4000;
        tick();
        jalr_resolve_valid = 0;
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL jalr_res_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_next_pc !== 32'h4000) begin errors++; $display("FAIL jalr_res_next_pc: got %h exp 4000", pred_next_pc); end
        checks++; if (pred_stall !== 1'b0) begin errors++; $display("FAIL jalr_res_stall: got %0b exp 0", pred_stall); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jalr_res_taken: got %0b exp 1", pred_taken); end
    endtask

    task automatic test_flush();
        lookup(32'h300, I_JALR);
        flush = 1; jalr_resolve_valid = 1; jalr_target = 32'h5000;
        if_valid = 1; if_pc = 32'h700; if_instr = I_NOP;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 0;   // counter 2 -> 1 despite flush
        tick();
        idle_inputs();
        checks++; if (pred_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b exp 0", pred_stall); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b exp 0", pred_valid); end
        checks++; if (pred_next_pc !== 32'h4000) begin errors++; $display("FAIL flush_hold_pc: got %h exp 4000", pred_next_pc); end
        lookup(32'h600, I_NOP);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_next_pc !== 32'h604) begin errors++; $display("FAIL post_flush_next_pc: got %h exp 604", pred_next_pc); end
        lookup(32'h100, I_BR16);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_upd_taken: got %0b exp 0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;   // counter 1 -> 2, lookup sees 1
        lookup(32'h100, I_BR16);
        upd_valid = 0;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_old_taken: got %0b exp 0", pred_taken); end
        checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL rbw_old_next_pc: got %h exp 104", pred_next_pc); end
        lookup(32'h100, I_BR16);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL rbw_new_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_new_taken: got %0b exp 1", pred_taken); end
        checks++; if (pred_next_pc !== 32'h110) begin errors++; $display("FAIL rbw_new_next_pc: got %h exp 110", pred_next_pc); end
    endtask

    task automatic test_rdy();
        rdy = 0;
        if_valid = 1; if_pc = 32'h200; if_instr = I_JALM8;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 0;
        tick();
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL rdy_freeze_valid: got %0b exp 1", pred_valid); end
        tick();
        checks++; if (pred_next_pc !== 32'h110) begin errors++; $display("FAIL rdy_freeze_next_pc: got %h exp 110", pred_next_pc); end
        idle_inputs();
        rdy = 1;
        tick();
        lookup(32'h100, I_BR16);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rdy_pht_frozen: got %0b exp 1", pred_taken); end
        checks++; if (pred_next_pc !== 32'h110) begin errors++; $display("FAIL rdy_pht_next_pc: got %h exp 110", pred_next_pc); end
    endtask

    initial begin
        test_reset();
        test_branch_init();
        test_training();
        test_jal_and_other();
        test_jalr();
        test_flush();
        test_back_to_back();
        test_rdy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
- Parametrised successor to the fetch-stage predictor; sits between IF and the IF PC mux and takes commit feedback from the ROB.
- Replaces static "always taken" with a pattern history table (PHT) of saturating counters, indexed by PC, trained on every committed conditional branch.
- Decodes JAL, JALR and branches, computes targets, and stalls IF while a JALR target is unresolved.
- Flushes cleanly on mispredict.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- INDEX_BITS, 8, PHT index width; PHT depth = 2^INDEX_BITS; index = pc[INDEX_BITS+1:2].
- CTR_BITS, 2, saturating counter width (>=1).
- CTR_INIT, 1, counter reset value; must be < 2^CTR_BITS; default is weakly not-taken.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; when low, no state or output changes.
- if_valid  in  1  IF presents a fetched instruction this cycle.
- if_pc  in  ADDR_WIDTH  PC of the fetched instruction.
- if_instr  in  32  fetched instruction word.
- pred_valid  out  1  one-cycle pulse; prediction outputs valid.
- pred_is_jump  out  1  instruction is JAL/JALR/branch.
- pred_taken  out  1  predicted taken.
- pred_next_pc  out  ADDR_WIDTH  next fetch PC.
- pred_stall  out  1  IF must hold; JALR target pending.
- upd_valid  in  1  ROB commits a conditional branch.
- upd_pc  in  ADDR_WIDTH  PC of the committed branch.
- upd_taken  in  1  actual outcome of the committed branch.
- jalr_resolve_valid  in  1  ALU broadcasts a resolved JALR.
- jalr_target  in  ADDR_WIDTH  resolved JALR target.
- flush  in  1  mispredict; discard in-flight prediction state.

Behaviour:
- **rdy and reset**
  - All state changes only on a rising clk edge with rdy=1; rst takes effect regardless of rdy.
  - Reset: every PHT entry = CTR_INIT, state = IDLE; pred_valid, pred_is_jump, pred_taken and pred_stall = 0; pred_next_pc = 0.
- **States**
  - IDLE: accepts lookups.
  - WAIT_JALR: waits for jalr_resolve_valid.
- **Lookup (IDLE, if_valid=1), latency 1 cycle, all outputs registered, pred_valid=1 for exactly one cycle.**
  - Decode is on opcode = if_instr[6:0].
  - JAL (1101111): is_jump=1, taken=1, next_pc = if_pc + sext(J-imm).
  - Branch (1100011): is_jump=1, taken = PHT[idx] MSB.
    - If taken: next_pc = if_pc + sext(B-imm).
    - Otherwise: next_pc = if_pc + 4.
  - JALR (1100111): is_jump=1, taken=1, pred_valid=0, pred_stall=1, state→WAIT_JALR.
  - Other opcodes: is_jump=0, taken=0, next_pc = if_pc + 4.
  - Immediates are sign-extended to ADDR_WIDTH; all adds are modulo 2^ADDR_WIDTH.
- **WAIT_JALR**
  - if_valid is ignored.
  - On jalr_resolve_valid: pred_valid=1, is_jump=1, taken=1, next_pc = jalr_target, pred_stall=0, state→IDLE, next cycle.
  - jalr_resolve_valid in IDLE is ignored.
- **Training (any state, upd_valid=1)**
  - PHT[upd_pc[INDEX_BITS+1:2]] increments if upd_taken, decrements otherwise.
  - Saturates at 2^CTR_BITS-1 and at 0.
  - Write is visible to lookups from the next cycle. A same-cycle lookup to the same index sees the old value (read-before-write).
- **Aliasing**: different PCs with the same index share one counter; this is accepted.
- **Flush (priority over lookup and JALR resolve)**
  - Next cycle: pred_valid=0, pred_stall=0, state→IDLE.
  - Same-cycle if_valid and jalr_resolve_valid are dropped.
  - A same-cycle upd_valid is still applied, because commits are architectural.
  - PHT contents are preserved.
- **Outputs when pred_valid=0**: pred_is_jump, pred_taken and pred_next_pc hold their last values.

Test Plan:
- Reset, then a branch at pc 0x100 with offset +16 → pred_valid=1 next cycle, taken=0, next_pc=0x104 (CTR_INIT=1).
- 2× upd_valid/upd_taken=1 at pc 0x100, then lookup → taken=1, next_pc=0x110. 5 more taken updates followed by 3 not-taken updates → counter 0 and taken=0 (saturation in both directions).
- JAL at 0x200 with imm -8 → next_pc=0x1F8, taken=1, 1-cycle latency.
- JALR at 0x300 → pred_stall=1 next cycle. An if_valid during the wait is ignored. jalr_resolve_valid with target 0x4000 → pred_valid=1, next_pc=0x4000, stall=0.
- JALR pending, then flush together with jalr_resolve_valid → stall=0, pred_valid=0, state IDLE. The next lookup works normally.
- Same-cycle upd_valid (taken, pc 0x100) with a lookup at 0x100 → lookup uses the old counter; the following lookup sees the updated counter. Also check that rdy=0 freezes all outputs and the PHT.
